lighting_scheduler: RTL

Sequencing controller for the `ActiveLamps` lamp-selection datapath. It cycles the one-hot time code through four day phases and, at each phase change, samples the user-light and room-length inputs and presents them to `ActiveLamps`. It then latches the resulting lamp mask and walks the driven lamp outputs toward that mask one lamp at a time. It also grants a manual override through a req/ack handshake. It sits between the panel/sensor inputs and the lamp drivers; `ActiveLamps` is instantiated beside it in the parent.

---
 rtl/lighting_pkg.sv | 28 ++
 rtl/lamp_stepper.sv | 60 ++++++
 rtl/lighting_scheduler.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/lighting_pkg.sv
// Shared types and constants for the lamp sequencing controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lighting_pkg;

  // Controller states: sample the panel, let ActiveLamps settle, ramp toward
  // the target mask, hold it, or hand the lamps to a manual override.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SAMPLE = 3'd1,
    SETTLE = 3'd2,
    RAMP   = 3'd3,
    HOLD   = 3'd4,
    OVR    = 3'd5
  } state_t;

  // One-hot day-phase codes, in rotation order.
  localparam logic [3:0] TC_NIGHT   = 4'b0001;
  localparam logic [3:0] TC_MORNING = 4'b0010;
  localparam logic [3:0] TC_NOON    = 4'b0100;
  localparam logic [3:0] TC_EVENING = 4'b1000;

  // Advance to the next day phase (rotate left, evening wraps to night).
  function automatic logic [3:0] next_tcode(input logic [3:0] tc);
    return {tc[2:0], tc[3]};
  endfunction

endpackage

// File: rtl/lamp_stepper.sv
// Moves a lamp mask toward its target one bit per STEP_TICKS enabled cycles.
// Latency: first toggle STEP_TICKS enabled cycles after clr; next is combinational.
// Backpressure: step_en low freezes the step counter; no toggle is offered.
module lamp_stepper #(
  parameter int STEP_TICKS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step_en,
  input  logic       clr,
  input  logic [3:0] cur,
  input  logic [3:0] target,
  output logic [3:0] next,
  output logic       done
);

  localparam int CW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_TICKS - 1);

  logic [CW-1:0] step_cnt;
  logic          terminal;
  logic [3:0]    diff;
  logic [3:0]    flip;

  assign terminal = step_en && (step_cnt == LAST);
  assign diff     = cur ^ target;
  assign done     = (diff == 4'b0000);

  // Step counter: restarts on clr, counts only while stepping is enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt <= '0;
    end else if (clr) begin
      step_cnt <= '0;
    end else if (step_en) begin
      step_cnt <= terminal ? '0 : step_cnt + CW'(1);
    end
  end

  // Select the lowest-index lamp that still disagrees with the target.
  always_comb begin
    flip = 4'b0000;
    casez (diff)
      4'b???1: flip = 4'b0001;
      4'b??10: flip = 4'b0010;
      4'b?100: flip = 4'b0100;
      4'b1000: flip = 4'b1000;
      default: flip = 4'b0000;
    endcase
  end

  // Offer the toggled mask only on the terminal count of the step interval.
  always_comb begin
    next = cur;
    if (terminal) begin
      next = cur ^ flip;
    end
  end

endmodule

// File: rtl/lighting_scheduler.sv
// Rotates day phases, samples panel inputs for ActiveLamps, ramps lamps to the result.
// Latency: sample 1 cycle after phase wrap, target 1 later, then 1 lamp per STEP_TICKS.
// Backpressure: ovr_req/ovr_ack handshake; enable low freezes timers and the ramp.
module lighting_scheduler
  import lighting_pkg::*;
#(
  parameter int PHASE_TICKS = 1000,
  parameter int STEP_TICKS  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [3:0] ulight_in,
  input  logic [3:0] lenght_in,
  output logic [3:0] tcode,
  output logic [3:0] ulight,
  output logic [3:0] lenght,
  input  logic [3:0] active_lights,
  output logic [3:0] lamp_out,
  input  logic       ovr_req,
  input  logic [3:0] ovr_mask,
  output logic       ovr_ack,
  output logic       busy
);

  localparam int PW = (PHASE_TICKS > 1) ? $clog2(PHASE_TICKS) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(PHASE_TICKS - 1);

  state_t     state;
  state_t     state_nxt;
  logic [PW-1:0] phase_cnt;
  logic       wrap;
  logic [3:0] target;
  logic       pend_sample;
  logic       step_en;
  logic       step_clr;
  logic [3:0] step_next;
  logic       step_done;

  assign wrap    = enable && (phase_cnt == PHASE_LAST);
  assign step_en = (state == RAMP) && enable;
  // Counter restarts whenever the ramp is (re)entered, from SETTLE or OVR.
  assign step_clr = (state_nxt == RAMP) && (state != RAMP);

  assign ovr_ack = (state == OVR);
  assign busy    = (lamp_out != target) || (state == SAMPLE) || (state == SETTLE);

  lamp_stepper #(
    .STEP_TICKS (STEP_TICKS)
  ) u_stepper (
    .clk     (clk),
    .rst_n   (rst_n),
    .step_en (step_en),
    .clr     (step_clr),
    .cur     (lamp_out),
    .target  (target),
    .next    (step_next),
    .done    (step_done)
  );

  // Phase timer and time-code rotation; both frozen while enable is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_cnt <= '0;
      tcode     <= TC_NIGHT;
    end else if (enable) begin
      phase_cnt <= wrap ? '0 : phase_cnt + PW'(1);
      if (wrap) begin
        tcode <= next_tcode(tcode);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: override beats a phase wrap; SAMPLE/SETTLE never interrupted.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ovr_req)     state_nxt = OVR;
        else if (enable) state_nxt = SAMPLE;
      end
      SAMPLE: state_nxt = SETTLE;
      SETTLE: state_nxt = RAMP;
      RAMP: begin
        if (ovr_req)                  state_nxt = OVR;
        else if (wrap)                state_nxt = SAMPLE;
        else if (enable && step_done) state_nxt = HOLD;
      end
      HOLD: begin
        if (ovr_req)   state_nxt = OVR;
        else if (wrap) state_nxt = SAMPLE;
      end
      OVR: begin
        // A wrap on the release cycle itself is folded into the pending flag.
        if (!ovr_req) state_nxt = (pend_sample || wrap) ? SAMPLE : RAMP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Panel inputs latched in SAMPLE; ActiveLamps result latched one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ulight <= 4'b0000;
      lenght <= 4'b0000;
      target <= 4'b0000;
    end else begin
      if (state == SAMPLE) begin
        ulight <= ulight_in;
        lenght <= lenght_in;
      end
      if (state == SETTLE) begin
        target <= active_lights;
      end
    end
  end

  // Remember a phase wrap that landed while the override owns the lamps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_sample <= 1'b0;
    end else if (state == SAMPLE) begin
      pend_sample <= 1'b0;
    end else if (wrap && (state_nxt == OVR)) begin
      pend_sample <= 1'b1;
    end
  end

  // Lamp drivers: follow the override mask, otherwise take ramp steps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lamp_out <= 4'b0000;
    end else if (state_nxt == OVR) begin
      lamp_out <= ovr_mask;
    end else if (state == RAMP) begin
      lamp_out <= step_next;
    end
  end

endmodule
